// File: rtl/count_monitor.sv
// count_monitor
//    Filters a free-running 4-bit ripple counter into the clk domain, counts
//    accepted 15->0 wraps and raises a handshaked threshold flag.
//
// Optional feature: define COUNT_MONITOR_ERR_EN to build the illegal-step
// checker (sticky ERR). Without it ERR is tied low.
//
// Ports
//    CLK        system clock, rising edge
//    RESET      asynchronous active-high reset
//    COUNT_IN   raw ripple-counter value (asynchronous, may glitch)
//    THRESH     wrap count that raises HIT; 0 disables HIT
//    ACK        level acknowledge for HIT
//    COUNT_SYNC last accepted count value
//    VALID      one-cycle pulse when COUNT_SYNC updates
//    WRAPS      saturating count of accepted 15->0 steps since last clear
//    HIT        threshold flag (high only in ST_HIT)
//    ERR        sticky illegal-step flag
//
// state       | meaning
// ST_IDLE     | waiting for WRAPS to reach a non-zero THRESH
// ST_HIT      | HIT asserted, waiting for ACK=1 (clears WRAPS)
// ST_WAIT_LOW | acknowledged, waiting for ACK=0
module count_monitor #(
   parameter int WRAP_W   = 8,
   parameter int STABLE_N = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [3:0]        COUNT_IN,
   input  logic [WRAP_W-1:0] THRESH,
   input  logic              ACK,
   output logic [3:0]        COUNT_SYNC,
   output logic              VALID,
   output logic [WRAP_W-1:0] WRAPS,
   output logic              HIT,
   output logic              ERR
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HIT      = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   state_t            state;
   logic [3:0]        sync1;
   logic [3:0]        sync2;
   logic [3:0]        run;     // edges for which sync2 has kept its value
   logic [4:0]        held;    // cycles sync2 has shown its current value
   logic              accept;
   logic              wrap;
   logic [WRAP_W-1:0] wraps_inc;

   assign held      = {1'b0, run} + 5'd1;
   assign accept    = (held >= 5'(STABLE_N)) && (sync2 != COUNT_SYNC);
   assign wrap      = accept && (COUNT_SYNC == 4'hF) && (sync2 == 4'h0);
   assign wraps_inc = (WRAPS == {WRAP_W{1'b1}}) ? WRAPS : WRAPS + WRAP_W'(1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1      <= 4'h0;
         sync2      <= 4'h0;
         run        <= 4'h0;
         COUNT_SYNC <= 4'h0;
         VALID      <= 1'b0;
      end else begin
         sync1 <= COUNT_IN;
         sync2 <= sync1;
         // run restarts whenever the next sync2 value differs from the current one
         if (sync1 == sync2)
            run <= (run == 4'hF) ? run : run + 4'd1;
         else
            run <= 4'h0;
         VALID <= accept;
         if (accept)
            COUNT_SYNC <= sync2;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
         HIT   <= 1'b0;
         WRAPS <= '0;
      end else begin
         if (wrap)
            WRAPS <= wraps_inc;
         case (state)
            ST_IDLE: begin
               if ((THRESH != '0) && (WRAPS >= THRESH)) begin
                  state <= ST_HIT;
                  HIT   <= 1'b1;
               end
            end
            ST_HIT: begin
               if (ACK) begin
                  state <= ST_WAIT_LOW;
                  HIT   <= 1'b0;
                  // a wrap landing on the acknowledge edge survives the clear
                  WRAPS <= wrap ? WRAP_W'(1) : '0;
               end
            end
            ST_WAIT_LOW: begin
               if (!ACK)
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               HIT   <= 1'b0;
            end
         endcase
      end
   end

`ifdef COUNT_MONITOR_ERR_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         ERR <= 1'b0;
      else if (accept && (sync2 != (COUNT_SYNC + 4'd1)))
         ERR <= 1'b1;
   end
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

   localparam int WRAP_W = 8;
`ifdef COUNT_MONITOR_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RESET;
   logic [3:0]        COUNT_IN;
   logic [WRAP_W-1:0] THRESH;
   logic              ACK;
   logic [3:0]        COUNT_SYNC;
   logic              VALID;
   logic [WRAP_W-1:0] WRAPS;
   logic              HIT;
   logic              ERR;

   int n_cmp = 0;
   int n_bad = 0;

   count_monitor #(.WRAP_W(WRAP_W), .STABLE_N(2)) dut (
      .CLK(CLK), .RESET(RESET), .COUNT_IN(COUNT_IN), .THRESH(THRESH), .ACK(ACK),
      .COUNT_SYNC(COUNT_SYNC), .VALID(VALID), .WRAPS(WRAPS), .HIT(HIT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step(1);
      RESET = 1'b0;
      step(1);
   endtask

   task automatic set_val(input logic [3:0] v, input int hold);
      COUNT_IN = v;
      step(hold);
   endtask

   task automatic count_run(input int first, input int last, input int hold);
      for (int v = first; v <= last; v++)
         set_val(4'(v), hold);
   endtask

   initial begin
      logic saw_valid;
      RESET    = 1'b1;
      COUNT_IN = 4'h0;
      THRESH   = '0;
      ACK      = 1'b0;
      #2;
      chk("rst_sync", 32'(COUNT_SYNC), 0);
      chk("rst_wraps", 32'(WRAPS), 0);
      chk("rst_hit", 32'(HIT), 0);
      chk("rst_valid", 32'(VALID), 0);
      chk("rst_err", 32'(ERR), 0);
      step(2);
      RESET = 1'b0;
      step(2);

      // 0 -> 1: VALID only on 4th edge
      COUNT_IN = 4'h1;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         chk($sformatf("step01_valid_e%0d", e), 32'(VALID), (e == 4) ? 1 : 0);
         if (e == 3) chk("step01_sync_e3", 32'(COUNT_SYNC), 0);
      end
      chk("step01_sync", 32'(COUNT_SYNC), 1);

      // one-cycle glitch to 3
      COUNT_IN = 4'h3;
      step(1);
      COUNT_IN = 4'h1;
      saw_valid = 1'b0;
      for (int e = 0; e < 6; e++) begin
         step(1);
         if (VALID) saw_valid = 1'b1;
      end
      chk("glitch_valid", 32'(saw_valid), 0);
      chk("glitch_sync", 32'(COUNT_SYNC), 1);
      chk("glitch_err", 32'(ERR), 0);

      // THRESH=2, two full passes
      do_reset();
      THRESH = 8'd2;
      for (int p = 0; p < 2; p++) begin
         count_run(1, 15, 6);
         set_val(4'h0, 6);
      end
      chk("thr_wraps", 32'(WRAPS), 2);
      chk("thr_hit", 32'(HIT), 1);
      ACK = 1'b1;
      step(1);
      chk("ack_hit", 32'(HIT), 0);
      chk("ack_wraps", 32'(WRAPS), 0);
      step(3);
      chk("waitlow_hit", 32'(HIT), 0);
      ACK = 1'b0;
      step(3);
      chk("idle_hit", 32'(HIT), 0);
      chk("idle_wraps", 32'(WRAPS), 0);

      // ACK coincides with accepted 15->0 while in HIT
      do_reset();
      THRESH = 8'd1;
      count_run(1, 15, 6);
      set_val(4'h0, 6);
      chk("coin_hit_pre", 32'(HIT), 1);
      count_run(1, 15, 6);
      chk("coin_hit_hold", 32'(HIT), 1);
      COUNT_IN = 4'h0;
      step(3);
      ACK = 1'b1;
      step(1);
      chk("coin_valid", 32'(VALID), 1);
      chk("coin_wraps", 32'(WRAPS), 1);
      chk("coin_hit", 32'(HIT), 0);
      step(3);
      chk("coin_waitlow", 32'(HIT), 0);
      ACK = 1'b0;
      step(2);
      chk("coin_rehit", 32'(HIT), 1);
      chk("coin_wraps_kept", 32'(WRAPS), 1);

      // THRESH=0 disables HIT; then async reset mid-count
      do_reset();
      THRESH = '0;
      count_run(1, 15, 6);
      set_val(4'h0, 6);
      count_run(1, 9, 6);
      chk("mid_sync", 32'(COUNT_SYNC), 9);
      chk("mid_wraps", 32'(WRAPS), 1);
      chk("thr0_hit", 32'(HIT), 0);
      #2;
      RESET = 1'b1;
      #1;
      chk("arst_sync", 32'(COUNT_SYNC), 0);
      chk("arst_wraps", 32'(WRAPS), 0);
      chk("arst_valid", 32'(VALID), 0);
      chk("arst_hit", 32'(HIT), 0);
      chk("arst_err", 32'(ERR), 0);
      step(1);
      RESET = 1'b0;
      COUNT_IN = 4'h0;
      step(2);

      // illegal step 4 -> 7
      do_reset();
      count_run(1, 4, 6);
      chk("legal_err", 32'(ERR), 0);
      set_val(4'h7, 6);
      chk("ill_sync", 32'(COUNT_SYNC), 7);
      chk("ill_err", 32'(ERR), 32'(ERR_ON));
      ACK = 1'b1;
      step(2);
      ACK = 1'b0;
      step(2);
      chk("ill_err_sticky", 32'(ERR), 32'(ERR_ON));

      // WRAPS saturation
      do_reset();
      for (int w = 0; w < 257; w++) begin
         count_run(1, 15, 4);
         set_val(4'h0, 4);
         if (w == 253) chk("sat_254", 32'(WRAPS), 254);
      end
      chk("sat_wraps", 32'(WRAPS), 255);
      chk("sat_hit", 32'(HIT), 0);
      chk("sat_err", 32'(ERR), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
